// File: rtl/dht11_responder.sv
// dht11_responder: sensor side of the DHT11 single-wire protocol (start detect, ACK, 40-bit frame).
// Optional feature macro DHT11_FAULT_INJECT_EN: fault_checksum inverts the transmitted checksum.
module dht11_responder #(
    parameter int unsigned CLKS_PER_US   = 50,
    parameter int unsigned START_MIN_US  = 18000,
    parameter int unsigned RESP_DELAY_US = 30,
    parameter int unsigned ACK_US        = 80,
    parameter int unsigned BIT_LOW_US    = 50,
    parameter int unsigned BIT0_HIGH_US  = 26,
    parameter int unsigned BIT1_HIGH_US  = 70
) (
    input  logic       clock,
    input  logic       reset,
    inout  wire        transmission_line,
    input  logic [7:0] hum_int,
    input  logic [7:0] hum_float,
    input  logic [7:0] temp_int,
    input  logic [7:0] temp_float,
    input  logic       fault_checksum,
    output logic       busy,
    output logic       frame_done
);
    localparam logic [31:0] START_CYCLES   = 32'(START_MIN_US * CLKS_PER_US);
    localparam logic [31:0] RESP_CYCLES    = 32'(RESP_DELAY_US * CLKS_PER_US);
    localparam logic [31:0] ACK_CYCLES     = 32'(ACK_US * CLKS_PER_US);
    localparam logic [31:0] BIT_LOW_CYCLES = 32'(BIT_LOW_US * CLKS_PER_US);
    localparam logic [31:0] BIT0_CYCLES    = 32'(BIT0_HIGH_US * CLKS_PER_US);
    localparam logic [31:0] BIT1_CYCLES    = 32'(BIT1_HIGH_US * CLKS_PER_US);

    typedef enum logic [2:0] {
        IDLE, HOST_LOW, RESP_DELAY, ACK_LOW, ACK_HIGH, BIT_LOW, BIT_HIGH, END_LOW
    } state_t;

    state_t      state;
    logic        line_meta;
    logic        line_sync;
    logic        drive_low;
    logic [31:0] timer;
    logic [31:0] phase_len;
    logic        phase_end;
    logic [5:0]  bit_idx;
    logic [39:0] shift_reg;
    logic [7:0]  checksum;
    logic [7:0]  checksum_tx;

    // Open-drain: only ever pull low or let the external pull-up win.
    assign transmission_line = drive_low ? 1'b0 : 1'bz;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        checksum = hum_int + hum_float + temp_int + temp_float;
`ifdef DHT11_FAULT_INJECT_EN
        checksum_tx = fault_checksum ? ~checksum : checksum;
`else
        checksum_tx = checksum;
`endif
    end

`ifndef DHT11_FAULT_INJECT_EN
    logic unused_fault;
    assign unused_fault = fault_checksum;
`endif

    always_comb begin
        case (state)
            RESP_DELAY:        phase_len = RESP_CYCLES;
            ACK_LOW, ACK_HIGH: phase_len = ACK_CYCLES;
            BIT_HIGH:          phase_len = shift_reg[39] ? BIT1_CYCLES : BIT0_CYCLES;
            default:           phase_len = BIT_LOW_CYCLES;
        endcase
    end

    // Timer is cleared on phase entry, so a phase lasts exactly phase_len cycles.
    assign phase_end = (timer == phase_len - 32'd1);

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clock) begin
        if (reset) begin
            line_meta <= 1'b1;
            line_sync <= 1'b1;
        end else begin
            line_meta <= transmission_line;
            line_sync <= line_meta;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: the shift register is reset too; it is a plain register, not a RAM.
            state      <= IDLE;
            drive_low  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            timer      <= '0;
            bit_idx    <= 6'd39;
            shift_reg  <= '0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!line_sync) begin
                        timer <= '0;
                        state <= HOST_LOW;
                    end
                end
                HOST_LOW: begin
                    if (!line_sync) begin
                        if (timer != '1) timer <= timer + 32'd1;
                    end else begin
                        timer <= '0;
                        if (timer >= START_CYCLES) begin
                            shift_reg <= {hum_int, hum_float, temp_int, temp_float, checksum_tx};
                            bit_idx   <= 6'd39;
                            busy      <= 1'b1;
                            state     <= RESP_DELAY;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    if (!phase_end) begin
                        timer <= timer + 32'd1;
                    end else begin
                        timer <= '0;
                        case (state)
                            RESP_DELAY: begin drive_low <= 1'b1; state <= ACK_LOW;  end
                            ACK_LOW:    begin drive_low <= 1'b0; state <= ACK_HIGH; end
                            ACK_HIGH:   begin drive_low <= 1'b1; state <= BIT_LOW;  end
                            BIT_LOW:    begin drive_low <= 1'b0; state <= BIT_HIGH; end
                            BIT_HIGH: begin
                                drive_low <= 1'b1;
                                if (bit_idx == 6'd0) begin
                                    state <= END_LOW;
                                end else begin
                                    shift_reg <= {shift_reg[38:0], 1'b0};
                                    bit_idx   <= bit_idx - 6'd1;
                                    state     <= BIT_LOW;
                                end
                            end
                            default: begin
                                drive_low  <= 1'b0;
                                busy       <= 1'b0;
                                frame_done <= 1'b1;
                                state      <= IDLE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dht11_responder.sv
// Bench for dht11_responder: a host model issues start pulses, a line decoder measures the
// response and compares each frame against a scoreboard queue filled when the start is issued.
`timescale 1ns/1ps
module tb_dht11_responder;
    localparam int CPU    = 2;
    localparam int BUDGET = 400;
`ifdef DHT11_FAULT_INJECT_EN
    localparam bit FAULT_EN = 1'b1;
`else
    localparam bit FAULT_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       host_drive = 1'b0;
    logic [7:0] hum_int = 8'h37, hum_float = 8'h00, temp_int = 8'h18, temp_float = 8'h00;
    logic       fault_checksum = 1'b0;
    logic       busy, frame_done;
    wire        line;

    assign line = host_drive ? 1'b0 : 1'bz;
    pullup (line);

    int vectors = 0;
    int miscompares = 0;
    int done_count = 0;
    int exp_done = 0;
    logic [39:0] exp_q[$];

    dht11_responder #(.CLKS_PER_US(CPU), .START_MIN_US(100)) dut (
        .clock(clock), .reset(reset), .transmission_line(line),
        .hum_int(hum_int), .hum_float(hum_float), .temp_int(temp_int), .temp_float(temp_float),
        .fault_checksum(fault_checksum), .busy(busy), .frame_done(frame_done)
    );

    always #5 clock = ~clock;
    always @(negedge clock) if (frame_done === 1'b1) done_count++;

    initial begin
        #950000;
        $display("FAIL watchdog: observed no finish, expected finish before 95000 cycles");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [39:0] exp_frame(input logic [7:0] a, input logic [7:0] b,
                                              input logic [7:0] c, input logic [7:0] d,
                                              input logic inv);
        logic [7:0] cs;
        cs = a + b + c + d;
        if (inv) cs = ~cs;
        return {a, b, c, d, cs};
    endfunction

    // Counts negedges while the line holds lvl; stops at the first differing sample or budget.
    task automatic measure(input logic lvl, output int n);
        n = 0;
        while (line === lvl && n < BUDGET) begin
            n++;
            @(negedge clock);
        end
    endtask

    task automatic host_start(input int us, input bit queue_it);
        @(negedge clock);
        host_drive = 1'b1;
        repeat (us * CPU) @(negedge clock);
        host_drive = 1'b0;
        if (queue_it) begin
            exp_q.push_back(exp_frame(hum_int, hum_float, temp_int, temp_float,
                                      FAULT_EN && fault_checksum));
            exp_done++;
        end
    endtask

    task automatic receive_frame(input int change_bit, input logic [7:0] new_temp,
                                 output logic [39:0] got);
        int n, lo, hi, bad_lo, bad_hi;
        logic [39:0] exp;
        got = '0;
        bad_lo = 0;
        bad_hi = 0;
        @(negedge clock);
        measure(1'b1, n);
        check("ack_latency", 64'(n + 1), 64'(30 * CPU + 3));
        check("busy_in_frame", 64'(busy), 64'd1);
        measure(1'b0, lo);
        check("ack_low", 64'(lo), 64'(80 * CPU));
        measure(1'b1, hi);
        check("ack_high", 64'(hi), 64'(80 * CPU));
        for (int i = 0; i < 40; i++) begin
            if (i == change_bit) temp_int = new_temp;
            measure(1'b0, lo);
            measure(1'b1, hi);
            if (lo != 50 * CPU) bad_lo++;
            if (hi != 26 * CPU && hi != 70 * CPU) bad_hi++;
            got = {got[38:0], (hi > 48 * CPU)};
            if (lo >= BUDGET || hi >= BUDGET) break;
        end
        check("bit_low_widths", 64'(bad_lo), 64'd0);
        check("bit_high_widths", 64'(bad_hi), 64'd0);
        measure(1'b0, lo);
        check("end_low", 64'(lo), 64'(50 * CPU));
        check("frame_done_pulse", 64'(frame_done), 64'd1);
        check("busy_after_frame", 64'(busy), 64'd0);
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        check("frame_data", 64'(got), 64'(exp));
    endtask

    initial begin
        logic [39:0] got;
        int lows, busy_seen, done_before, n;

        repeat (4) @(negedge clock);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_frame_done", 64'(frame_done), 64'd0);
        check("reset_line", 64'(line), 64'd1);
        reset = 1'b0;
        repeat (4) @(negedge clock);

        // Nominal reading.
        host_start(120, 1'b1);
        receive_frame(-1, 8'h00, got);
        check("case1_literal", 64'(got), 64'h37_0018_004F);
        repeat (3) @(negedge clock);
        check("case1_done_count", 64'(done_count), 64'(exp_done));

        // Too-short host pulse is ignored.
        host_start(60, 1'b0);
        lows = 0;
        busy_seen = 0;
        repeat (300) begin
            @(negedge clock);
            if (line !== 1'b1) lows++;
            if (busy !== 1'b0) busy_seen++;
        end
        check("short_no_drive", 64'(lows), 64'd0);
        check("short_busy", 64'(busy_seen), 64'd0);
        check("short_done_count", 64'(done_count), 64'(exp_done));

        // Input change mid-frame only affects the next frame.
        host_start(120, 1'b1);
        receive_frame(20, 8'h20, got);
        host_start(120, 1'b1);
        receive_frame(-1, 8'h00, got);
        check("case3_next_literal", 64'(got), 64'h37_0020_0057);
        temp_int = 8'h18;

        // Reset during ACK_LOW aborts without a completion pulse.
        host_start(120, 1'b0);
        @(negedge clock);
        measure(1'b1, n);
        repeat (5) @(negedge clock);
        done_before = done_count;
        reset = 1'b1;
        @(negedge clock);
        check("abort_line_released", 64'(line), 64'd1);
        check("abort_busy", 64'(busy), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (50) @(negedge clock);
        check("abort_no_done", 64'(done_count), 64'(done_before));
        host_start(120, 1'b1);
        receive_frame(-1, 8'h00, got);

        // Checksum fault request.
        fault_checksum = 1'b1;
        host_start(120, 1'b1);
        receive_frame(-1, 8'h00, got);
        check("fault_checksum_byte", 64'(got[7:0]), FAULT_EN ? 64'hB0 : 64'h4F);
        fault_checksum = 1'b0;

        // Back-to-back start requests.
        host_start(120, 1'b1);
        receive_frame(-1, 8'h00, got);
        host_start(120, 1'b1);
        receive_frame(-1, 8'h00, got);
        check("b2b_literal", 64'(got), 64'h37_0018_004F);
        repeat (3) @(negedge clock);
        check("final_done_count", 64'(done_count), 64'(exp_done));
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
